frog_hop_ctrl: RTL and testbench
================================

// Module: frog_hop_ctrl
// PURPOSE
//  Next-gen frog position controller: discrete, animated grid hops (one hop per key press) plus river-current drift.
//  Sits between the key decoder and the frog sprite drawer; all motion advances on the frame tick timer_done.
//  Frame clamping is parametrised, and a cooldown follows every hop.
// PARAMETERS
//  X_W        11   width of position outputs
//  START_X    320  reset / respawn X
//  START_Y    440  reset / respawn Y
//  FRAME_W    640  screen width, pixels
//  FRAME_H    480  screen height, pixels
//  SPRITE     20   frog sprite size; legal X in [0,FRAME_W-SPRITE], Y in [0,FRAME_H-SPRITE]
//  HOP_STEPS  5    ticks per hop animation
//  STEP       4    pixels per hop tick (hop distance = STEP*HOP_STEPS)
//  COOL_TICKS 2    ticks of cooldown after a hop
//  DRIFT_W    4    width of signed drift input
// PORTS
//  CLK            in   1        system clock
//  RESETn         in   1        asynchronous reset, active-low
//  timer_done     in   1        frame tick, 1-cycle pulse
//  reset_position in   1        synchronous respawn request
//  up/down/left/right in 1 each  key levels
//  bank_width     in   9        height of bottom bank; river is Y < FRAME_H-bank_width-SPRITE
//  drift_speed    in   DRIFT_W  signed px/tick added to X while in river
//  ObjectStartX   out  X_W      sprite top-left X
//  ObjectStartY   out  X_W      sprite top-left Y
//  hopping        out  1        high in HOP state
//  hop_dir        out  2        direction of current/last hop (dir_t)
//  hop_done       out  1        1-cycle pulse on the tick completing a hop
// BEHAVIOUR
//  Reset: X=START_X, Y=START_Y, state IDLE, hopping=0, hop_dir=DIR_UP, hop_done=0, key history=0, counters=0.
//  Priority per CLK edge: reset_position > timer_done > hold. reset_position restores reset values except key history.
//  Key edges: history registered only on timer_done; press = key high now and low at previous tick.
//  FSM (advances only on timer_done):
//   IDLE: pick first press by priority up>down>left>right. Accept if target (pos +/- STEP*HOP_STEPS) stays in legal range.
//         On accept: latch hop_dir, step_cnt=0, go HOP, no motion this tick. On reject: stay IDLE; the press is consumed.
//   HOP:  move STEP in hop_dir (up: Y-, down: Y+, left: X-, right: X+); step_cnt++.
//         On the HOP_STEPS-th step: hop_done=1 and go COOL (cool_cnt=0).
//   COOL: cool_cnt++; after COOL_TICKS ticks go IDLE. Presses during HOP/COOL are ignored (history still updates).
//  Drift: on every tick in any state, if pre-update Y < FRAME_H-bank_width-SPRITE, add sign-extended drift_speed to X.
//         It is summed with any hop step in the same tick.
//  Arithmetic in signed X_W+2 bits; the X result saturates to [0,FRAME_W-SPRITE]. Y cannot leave range (checked at accept).
//  hop_done is registered and high for exactly the CLK cycle after the completing tick.
//  hopping = (state==HOP); latency from the tick to output change is 1 CLK.
//  Drift saturation at a wall during a horizontal hop: the hop still completes its steps; the position stays clamped.
// STRUCTURE
//  frog_pkg: typedef enum hop_state_t {ST_IDLE,ST_HOP,ST_COOL}; typedef enum logic[1:0] dir_t {DIR_UP,DIR_DOWN,DIR_LEFT,DIR_RIGHT}.
//  frog_pkg also holds the default FRAME_W/FRAME_H/SPRITE constants.
//  Sub-module frog_key_edge: 4-bit history register clocked on timer_done; outputs one-hot press vector.
//  The FSM, position datapath and clamp live in frog_hop_ctrl.
// TESTING (defaults)
//  1. Release RESETn -> X=320, Y=440, hopping=0, hop_done=0 before any tick.
//  2. Press up, hold for 20 ticks -> hopping on 2nd tick; Y 436,432,...,420; hop_done once; Y stays 420 (held key gives no re-hop).
//     Release, press again -> Y=400.
//  3. From Y=440 press down -> Y=460; press down again -> rejected, Y=460, hopping stays 0.
//  4. bank_width=100, Y=300, drift=-3, idle 10 ticks -> X=290.
//     With X=2, one tick -> X=0. With Y=440 (bank), drift has no effect.
//  5. Up and left pressed on the same tick -> hop_dir=DIR_UP, only Y changes.
//  6. reset_position asserted after the 3rd hop step -> next cycle X=320, Y=440, ST_IDLE, hopping=0, no hop_done.

Source files
------------

// File: rtl/frog_pkg.sv
// Shared types and default frame geometry for the frog hop controller.
package frog_pkg;

    localparam int FRAME_W_DEF = 640;
    localparam int FRAME_H_DEF = 480;
    localparam int SPRITE_DEF  = 20;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOP,
        ST_COOL
    } hop_state_t;

    typedef enum logic [1:0] {
        DIR_UP,
        DIR_DOWN,
        DIR_LEFT,
        DIR_RIGHT
    } dir_t;

endpackage

// File: rtl/frog_key_edge.sv
// Frame-rate key edge detector. Key levels are sampled only on the frame tick,
// so a press is a key that is high now but was low at the previous tick.
// The output is a one-hot vector picking the highest-priority press:
// bit0 up, bit1 down, bit2 left, bit3 right (up wins).
module frog_key_edge (
    input  logic       CLK,
    input  logic       RESETn,
    input  logic       timer_done,
    input  logic       up,
    input  logic       down,
    input  logic       left,
    input  logic       right,
    output logic [3:0] press
);

    logic [3:0] keys;
    logic [3:0] history;
    logic [3:0] raw_press;

    assign keys      = {right, left, down, up};
    assign raw_press = keys & ~history;

    // Remember key levels as they were at the last frame tick
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn)
            history <= '0;
        else if (timer_done)
            history <= keys;
    end

    // Reduce simultaneous presses to a single one-hot request
    always_comb begin
        press = 4'b0000;
        if (raw_press[0])
            press = 4'b0001;
        else if (raw_press[1])
            press = 4'b0010;
        else if (raw_press[2])
            press = 4'b0100;
        else if (raw_press[3])
            press = 4'b1000;
    end

endmodule

// File: rtl/frog_hop_ctrl.sv
// Frog position controller: animated grid hops with post-hop cooldown,
// river-current drift on X while above the bank, and X saturation at the
// frame walls. All motion advances on the frame tick timer_done.
module frog_hop_ctrl
    import frog_pkg::*;
#(
    parameter int X_W        = 11,
    parameter int START_X    = 320,
    parameter int START_Y    = 440,
    parameter int FRAME_W    = FRAME_W_DEF,
    parameter int FRAME_H    = FRAME_H_DEF,
    parameter int SPRITE     = SPRITE_DEF,
    parameter int HOP_STEPS  = 5,
    parameter int STEP       = 4,
    parameter int COOL_TICKS = 2,
    parameter int DRIFT_W    = 4
) (
    input  logic                      CLK,
    input  logic                      RESETn,
    input  logic                      timer_done,
    input  logic                      reset_position,
    input  logic                      up,
    input  logic                      down,
    input  logic                      left,
    input  logic                      right,
    input  logic [8:0]                bank_width,
    input  logic signed [DRIFT_W-1:0] drift_speed,
    output logic [X_W-1:0]            ObjectStartX,
    output logic [X_W-1:0]            ObjectStartY,
    output logic                      hopping,
    output logic [1:0]                hop_dir,
    output logic                      hop_done
);

    localparam int SW  = X_W + 2;
    localparam int SCW = $clog2(HOP_STEPS + 1);
    localparam int CCW = $clog2(COOL_TICKS + 1);

    localparam logic signed [SW-1:0] ZERO       = '0;
    localparam logic signed [SW-1:0] X_MAX      = SW'(FRAME_W - SPRITE);
    localparam logic signed [SW-1:0] Y_MAX      = SW'(FRAME_H - SPRITE);
    localparam logic signed [SW-1:0] SPAN       = SW'(STEP * HOP_STEPS);
    localparam logic signed [SW-1:0] STEP_S     = SW'(STEP);
    localparam logic signed [SW-1:0] RIVER_BASE = SW'(FRAME_H - SPRITE);

    hop_state_t      state;
    logic [SCW-1:0]  step_cnt;
    logic [CCW-1:0]  cool_cnt;
    logic [3:0]      press;

    logic signed [SW-1:0] sx, sy, bw, drift_ext;
    logic signed [SW-1:0] dx, dy, x_sum;
    logic signed [SW-1:0] t_up, t_down, t_left, t_right;
    logic                 in_river;
    logic [X_W-1:0]       x_next, y_next;
    dir_t                 sel_dir;
    logic                 sel_valid, accept;

    frog_key_edge u_key_edge (
        .CLK        (CLK),
        .RESETn     (RESETn),
        .timer_done (timer_done),
        .up         (up),
        .down       (down),
        .left       (left),
        .right      (right),
        .press      (press)
    );

    // Next position for this tick: drift plus hop step, X clamped, and hop acceptance
    always_comb begin
        sx        = $signed({2'b00, ObjectStartX});
        sy        = $signed({2'b00, ObjectStartY});
        bw        = $signed({{(SW-9){1'b0}}, bank_width});
        drift_ext = {{(SW-DRIFT_W){drift_speed[DRIFT_W-1]}}, drift_speed};
        in_river  = sy < (RIVER_BASE - bw);

        dx = in_river ? drift_ext : ZERO;
        dy = ZERO;
        if (state == ST_HOP) begin
            case (hop_dir)
                DIR_UP:    dy = -STEP_S;
                DIR_DOWN:  dy = STEP_S;
                DIR_LEFT:  dx = dx - STEP_S;
                default:   dx = dx + STEP_S;
            endcase
        end

        x_sum = sx + dx;
        if (x_sum < ZERO)
            x_next = '0;
        else if (x_sum > X_MAX)
            x_next = X_W'(X_MAX);
        else
            x_next = X_W'(x_sum);
        y_next = X_W'(sy + dy);

        sel_valid = 1'b1;
        case (press)
            4'b0001: sel_dir = DIR_UP;
            4'b0010: sel_dir = DIR_DOWN;
            4'b0100: sel_dir = DIR_LEFT;
            4'b1000: sel_dir = DIR_RIGHT;
            default: begin
                sel_dir   = DIR_UP;
                sel_valid = 1'b0;
            end
        endcase

        t_up    = sy - SPAN;
        t_down  = sy + SPAN;
        t_left  = sx - SPAN;
        t_right = sx + SPAN;
        case (sel_dir)
            DIR_UP:    accept = sel_valid && (t_up >= ZERO);
            DIR_DOWN:  accept = sel_valid && (t_down <= Y_MAX);
            DIR_LEFT:  accept = sel_valid && (t_left >= ZERO);
            default:   accept = sel_valid && (t_right <= X_MAX);
        endcase
    end

    // Hop FSM, position registers and registered status outputs
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            ObjectStartX <= X_W'(START_X);
            ObjectStartY <= X_W'(START_Y);
            state        <= ST_IDLE;
            hopping      <= 1'b0;
            hop_dir      <= DIR_UP;
            hop_done     <= 1'b0;
            step_cnt     <= '0;
            cool_cnt     <= '0;
        end else if (reset_position) begin
            ObjectStartX <= X_W'(START_X);
            ObjectStartY <= X_W'(START_Y);
            state        <= ST_IDLE;
            hopping      <= 1'b0;
            hop_dir      <= DIR_UP;
            hop_done     <= 1'b0;
            step_cnt     <= '0;
            cool_cnt     <= '0;
        end else begin
            hop_done <= 1'b0;
            if (timer_done) begin
                ObjectStartX <= x_next;
                ObjectStartY <= y_next;
                case (state)
                    ST_IDLE: begin
                        if (accept) begin
                            hop_dir  <= sel_dir;
                            step_cnt <= '0;
                            state    <= ST_HOP;
                            hopping  <= 1'b1;
                        end
                    end
                    ST_HOP: begin
                        step_cnt <= step_cnt + 1'b1;
                        if (step_cnt == SCW'(HOP_STEPS - 1)) begin
                            hop_done <= 1'b1;
                            cool_cnt <= '0;
                            state    <= ST_COOL;
                            hopping  <= 1'b0;
                        end
                    end
                    ST_COOL: begin
                        cool_cnt <= cool_cnt + 1'b1;
                        if (cool_cnt == CCW'(COOL_TICKS - 1))
                            state <= ST_IDLE;
                    end
                    default: begin
                        state   <= ST_IDLE;
                        hopping <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_frog_hop_ctrl.sv
// Testbench for frog_hop_ctrl: directed scenarios plus randomized ticks,
// every tick compared against a tick-level behavioural model of the frog.
module tb_frog_hop_ctrl;
    import frog_pkg::*;

    logic              CLK = 1'b0;
    logic              RESETn = 1'b0;
    logic              timer_done = 1'b0;
    logic              reset_position = 1'b0;
    logic              up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0;
    logic [8:0]        bank_width = 9'd100;
    logic signed [3:0] drift_speed = 4'sd0;
    logic [10:0]       ObjectStartX, ObjectStartY;
    logic              hopping;
    logic [1:0]        hop_dir;
    logic              hop_done;

    int vectors = 0;
    int miscompares = 0;

    // behavioural model state: position, remaining hop steps / cooldown ticks
    int         mx = 320, my = 440, hop_left = 0, cool_left = 0, mdir = 0, mdone = 0;
    logic [3:0] mprev = 4'b0000;
    logic       obs_done = 1'b0;

    frog_hop_ctrl dut (
        .CLK            (CLK),
        .RESETn         (RESETn),
        .timer_done     (timer_done),
        .reset_position (reset_position),
        .up             (up),
        .down           (down),
        .left           (left),
        .right          (right),
        .bank_width     (bank_width),
        .drift_speed    (drift_speed),
        .ObjectStartX   (ObjectStartX),
        .ObjectStartY   (ObjectStartY),
        .hopping        (hopping),
        .hop_dir        (hop_dir),
        .hop_done       (hop_done)
    );

    always #5 CLK = ~CLK;

    // One frame tick of the frog rules; k = {right,left,down,up}
    task automatic model_tick(input logic [3:0] k);
        int dx, dy, lim;
        logic [3:0] pr;
        logic found;
        lim   = 480 - int'(bank_width) - 20;
        dx    = (my < lim) ? int'(drift_speed) : 0;
        dy    = 0;
        mdone = 0;
        if (hop_left > 0) begin
            case (mdir)
                0: dy = -4;
                1: dy = 4;
                2: dx = dx - 4;
                default: dx = dx + 4;
            endcase
            hop_left--;
            if (hop_left == 0) begin
                mdone     = 1;
                cool_left = 2;
            end
        end else if (cool_left > 0) begin
            cool_left--;
        end else begin
            pr    = k & ~mprev;
            found = 1'b0;
            for (int i = 0; i < 4; i++) begin
                if (!found && pr[i]) begin
                    found = 1'b1;
                    if ((i == 0 && my - 20 >= 0) || (i == 1 && my + 20 <= 460) ||
                        (i == 2 && mx - 20 >= 0) || (i == 3 && mx + 20 <= 620)) begin
                        mdir     = i;
                        hop_left = 5;
                    end
                end
            end
        end
        mx = mx + dx;
        if (mx < 0)   mx = 0;
        if (mx > 620) mx = 620;
        my    = my + dy;
        mprev = k;
    endtask

    // Pulse one tick, compare all outputs, then confirm hop_done drops
    task automatic do_tick(input logic [3:0] k);
        @(negedge CLK);
        {right, left, down, up} = k;
        timer_done = 1'b1;
        @(negedge CLK);
        timer_done = 1'b0;
        model_tick(k);
        obs_done = hop_done;
        vectors++;
        if (ObjectStartX !== 11'(mx) || ObjectStartY !== 11'(my) ||
            hopping !== (hop_left > 0) || hop_dir !== 2'(mdir) || hop_done !== (mdone != 0)) begin
            miscompares++;
            $display("[TB] FAIL tick: got x=%0d y=%0d hop=%0b dir=%0d done=%0b, want x=%0d y=%0d hop=%0b dir=%0d done=%0b",
                     ObjectStartX, ObjectStartY, hopping, hop_dir, hop_done,
                     mx, my, (hop_left > 0), mdir, mdone);
        end
        @(negedge CLK);
        vectors++;
        if (hop_done !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL hop_done_width: got %0b want 0", hop_done);
        end
    endtask

    task automatic respawn();
        @(negedge CLK);
        reset_position = 1'b1;
        @(negedge CLK);
        reset_position = 1'b0;
        mx = 320; my = 440; hop_left = 0; cool_left = 0; mdir = 0; mdone = 0;
    endtask

    task automatic run_hop(input logic [3:0] k);
        do_tick(k);
        repeat (7) do_tick(4'b0000);
    endtask

    task automatic test_reset();
        RESETn = 1'b0;
        repeat (2) @(negedge CLK);
        RESETn = 1'b1;
        @(negedge CLK);
        vectors++;
        if (ObjectStartX !== 11'd320 || ObjectStartY !== 11'd440 || hopping !== 1'b0 ||
            hop_done !== 1'b0 || hop_dir !== 2'd0) begin
            miscompares++;
            $display("[TB] FAIL reset: got x=%0d y=%0d hop=%0b done=%0b dir=%0d, want 320 440 0 0 0",
                     ObjectStartX, ObjectStartY, hopping, hop_done, hop_dir);
        end
    endtask

    task automatic test_hop_up();
        int ndone;
        drift_speed = 4'sd0;
        respawn();
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            do_tick(4'b0001);
            if (obs_done) ndone++;
        end
        vectors++;
        if (ObjectStartY !== 11'd420 || ndone != 1) begin
            miscompares++;
            $display("[TB] FAIL hop_up_held: got y=%0d done_count=%0d, want y=420 done_count=1", ObjectStartY, ndone);
        end
        do_tick(4'b0000);
        run_hop(4'b0001);
        vectors++;
        if (ObjectStartY !== 11'd400) begin
            miscompares++;
            $display("[TB] FAIL hop_up_again: got y=%0d want 400", ObjectStartY);
        end
    endtask

    task automatic test_down_reject();
        respawn();
        run_hop(4'b0010);
        vectors++;
        if (ObjectStartY !== 11'd460) begin
            miscompares++;
            $display("[TB] FAIL hop_down: got y=%0d want 460", ObjectStartY);
        end
        do_tick(4'b0010);
        vectors++;
        if (ObjectStartY !== 11'd460 || hopping !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL down_reject: got y=%0d hop=%0b want y=460 hop=0", ObjectStartY, hopping);
        end
        do_tick(4'b0000);
    endtask

    task automatic test_drift();
        bank_width  = 9'd100;
        drift_speed = 4'sd0;
        respawn();
        repeat (7) run_hop(4'b0001);
        drift_speed = -4'sd3;
        repeat (10) do_tick(4'b0000);
        vectors++;
        if (ObjectStartY !== 11'd300 || ObjectStartX !== 11'd290) begin
            miscompares++;
            $display("[TB] FAIL drift_river: got x=%0d y=%0d want x=290 y=300", ObjectStartX, ObjectStartY);
        end
        repeat (96) do_tick(4'b0000);
        vectors++;
        if (ObjectStartX !== 11'd2) begin
            miscompares++;
            $display("[TB] FAIL drift_near_wall: got x=%0d want 2", ObjectStartX);
        end
        do_tick(4'b0000);
        vectors++;
        if (ObjectStartX !== 11'd0) begin
            miscompares++;
            $display("[TB] FAIL drift_clamp_left: got x=%0d want 0", ObjectStartX);
        end
        respawn();
        do_tick(4'b0000);
        vectors++;
        if (ObjectStartX !== 11'd320) begin
            miscompares++;
            $display("[TB] FAIL drift_on_bank: got x=%0d want 320", ObjectStartX);
        end
        drift_speed = 4'sd0;
    endtask

    task automatic test_priority();
        respawn();
        do_tick(4'b0101);
        vectors++;
        if (hop_dir !== 2'd0 || hopping !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL priority_dir: got dir=%0d hop=%0b want dir=0 hop=1", hop_dir, hopping);
        end
        repeat (7) do_tick(4'b0000);
        vectors++;
        if (ObjectStartX !== 11'd320 || ObjectStartY !== 11'd420) begin
            miscompares++;
            $display("[TB] FAIL priority_pos: got x=%0d y=%0d want 320 420", ObjectStartX, ObjectStartY);
        end
    endtask

    task automatic test_reset_position();
        respawn();
        do_tick(4'b0001);
        repeat (3) do_tick(4'b0000);
        respawn();
        vectors++;
        if (ObjectStartX !== 11'd320 || ObjectStartY !== 11'd440 || hopping !== 1'b0 || hop_done !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL respawn_mid_hop: got x=%0d y=%0d hop=%0b done=%0b want 320 440 0 0",
                     ObjectStartX, ObjectStartY, hopping, hop_done);
        end
        repeat (3) do_tick(4'b0000);
        run_hop(4'b0001);
    endtask

    task automatic test_random();
        logic [3:0] k;
        k = 4'b0000;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0) k = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 15) == 0) drift_speed = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 31) == 0) bank_width = 9'($urandom_range(0, 511));
            if ($urandom_range(0, 63) == 0) respawn();
            do_tick(k);
        end
    endtask

    initial begin
        test_reset();
        test_hop_up();
        test_down_reject();
        test_drift();
        test_priority();
        test_reset_position();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
